// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared constants and types for the board user-I/O blocks
package board_io_pkg;

  localparam int unsigned NUM_USER_IO             = 8;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  typedef struct packed {
    logic                   overrun;
    logic [NUM_USER_IO-1:0] rise;
    logic [NUM_USER_IO-1:0] fall;
  } evt_bundle_t;

  typedef enum logic {
    EVT_IDLE = 1'b0,
    EVT_HELD = 1'b1
  } evt_state_e;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchronizer, debounce counter and stable level for one input
// SW_DEBOUNCE_EN selects the counter; without it the synchronized level is taken each cycle.
module debounce_bit
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic raw,
  output logic state,
  output logic rose,
  output logic fell
);

`ifdef SW_DEBOUNCE_EN
  localparam bit USE_DEBOUNCE = 1'b1;
`else
  localparam bit USE_DEBOUNCE = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_state;
  logic                   w_sync;
  logic                   w_mismatch;
  logic                   w_toggle;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_sync != r_state);

  if (USE_DEBOUNCE && (DEBOUNCE_CYCLES > 1)) begin : g_counter
    localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] r_cnt;

    // Any return to equality, or an accepted toggle, restarts the count.
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        r_cnt <= '0;
      end else if (w_mismatch && (r_cnt != LAST)) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_toggle = w_mismatch && (r_cnt == LAST);
  end else begin : g_direct
    assign w_toggle = w_mismatch;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= 1'b0;
    end else if (w_toggle) begin
      r_state <= ~r_state;
    end
  end

  assign state = r_state;
  assign rose  = w_toggle & ~r_state;
  assign fell  = w_toggle & r_state;

endmodule

// File: rtl/debounced_inputs_8bits.sv
// rtl/debounced_inputs_8bits.sv - eight debounced switch inputs with coalescing edge-event handshake
// SW_DEBOUNCE_EN enables the per-bit debounce counters.
module debounced_inputs_8bits
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_USER_IO-1:0] sw_input,
  output logic [NUM_USER_IO-1:0] sw_state,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [NUM_USER_IO-1:0] evt_rise,
  output logic [NUM_USER_IO-1:0] evt_fall,
  output logic                   evt_overrun
);

  logic [NUM_USER_IO-1:0] w_new_rise;
  logic [NUM_USER_IO-1:0] w_new_fall;
  logic                   w_new_any;
  evt_state_e             r_evt_state;
  evt_state_e             w_evt_state_nxt;
  evt_bundle_t            r_evt;
  evt_bundle_t            w_evt_nxt;

  for (genvar gi = 0; gi < NUM_USER_IO; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_bit (
      .aclk   (aclk),
      .aresetn(aresetn),
      .raw    (sw_input[gi]),
      .state  (sw_state[gi]),
      .rose   (w_new_rise[gi]),
      .fell   (w_new_fall[gi])
    );
  end

  assign w_new_any = |(w_new_rise | w_new_fall);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_evt_state <= EVT_IDLE;
      r_evt       <= '0;
    end else begin
      r_evt_state <= w_evt_state_nxt;
      r_evt       <= w_evt_nxt;
    end
  end

  // A free register (idle, or accepted this cycle) takes fresh edges; a stalled one accumulates.
  always_comb begin
    w_evt_state_nxt = r_evt_state;
    w_evt_nxt       = r_evt;
    if ((r_evt_state == EVT_IDLE) || evt_ready) begin
      if (w_new_any) begin
        w_evt_state_nxt = EVT_HELD;
        w_evt_nxt       = '{overrun: 1'b0, rise: w_new_rise, fall: w_new_fall};
      end else if (r_evt_state == EVT_HELD) begin
        w_evt_state_nxt = EVT_IDLE;
        w_evt_nxt.rise  = '0;
        w_evt_nxt.fall  = '0;
      end
    end else begin
      w_evt_nxt.rise    = r_evt.rise | w_new_rise;
      w_evt_nxt.fall    = r_evt.fall | w_new_fall;
      w_evt_nxt.overrun = r_evt.overrun |
                          (|((w_new_rise | w_new_fall) & (r_evt.rise | r_evt.fall)));
    end
  end

  always_comb begin
    evt_valid   = (r_evt_state == EVT_HELD);
    evt_rise    = r_evt.rise;
    evt_fall    = r_evt.fall;
    evt_overrun = r_evt.overrun;
  end

endmodule

// File: tb/tb_debounced_inputs_8bits.sv
// tb/tb_debounced_inputs_8bits.sv - self-checking bench for debounced_inputs_8bits
module tb_debounced_inputs_8bits;

  localparam int DC   = 4;
  localparam int SYNC = 2;
`ifdef SW_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int LAT = DB ? (SYNC + DC) : (SYNC + 1);

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [7:0] sw_input;
  logic [7:0] sw_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_rise;
  logic [7:0] evt_fall;
  logic       evt_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_inq[$];
  logic [7:0] m_hist[$];
  logic [7:0] m_state;
  logic       m_valid;
  logic [7:0] m_rise;
  logic [7:0] m_fall;
  logic       m_ovr;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] exp_state;
  } vec_t;
  vec_t tbl[6];

  debounced_inputs_8bits #(
    .DEBOUNCE_CYCLES(DC),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .sw_input   (sw_input),
    .sw_state   (sw_state),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_rise   (evt_rise),
    .evt_fall   (evt_fall),
    .evt_overrun(evt_overrun)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Level accepted once DC consecutive synchronized samples all disagree with it.
  function automatic void model_update(input logic [7:0] x, input logic rdy, input logic rst_n);
    logic [7:0] s_used, nstate, flip, nr, nf;
    bit all_diff;
    if (!rst_n) begin
      m_inq = {};
      for (int k = 0; k < SYNC; k++) m_inq.push_back(8'h00);
      m_hist = {};
      m_state = 8'h00; m_valid = 1'b0; m_rise = 8'h00; m_fall = 8'h00; m_ovr = 1'b0;
      return;
    end
    s_used = m_inq[0];
    m_inq.push_back(x);
    void'(m_inq.pop_front());
    if (DB) begin
      m_hist.push_back(s_used);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      flip = 8'h00;
      if (m_hist.size() == DC) begin
        for (int b = 0; b < 8; b++) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][b] == m_state[b]) all_diff = 1'b0;
          flip[b] = all_diff;
        end
      end
      nstate = m_state ^ flip;
    end else begin
      nstate = s_used;
    end
    nr = nstate & ~m_state;
    nf = ~nstate & m_state;
    m_state = nstate;
    if (!m_valid || rdy) begin
      if ((nr | nf) != 8'h00) begin
        m_valid = 1'b1; m_rise = nr; m_fall = nf; m_ovr = 1'b0;
      end else if (m_valid) begin
        m_valid = 1'b0; m_rise = 8'h00; m_fall = 8'h00;
      end
    end else begin
      if (((nr | nf) & (m_rise | m_fall)) != 8'h00) m_ovr = 1'b1;
      m_rise = m_rise | nr;
      m_fall = m_fall | nf;
    end
  endfunction

  task automatic step();
    logic [7:0] x;
    logic r, rs;
    x = sw_input; r = evt_ready; rs = aresetn;
    @(posedge aclk);
    model_update(x, r, rs);
    @(negedge aclk);
    chk("model", {6'd0, sw_state, evt_valid, evt_rise, evt_fall, evt_overrun},
                 {6'd0, m_state, m_valid, m_rise, m_fall, m_ovr});
  endtask

  task automatic wait_valid(input string name, input int max_steps);
    int n;
    n = 0;
    while (!evt_valid && n < max_steps) begin
      step();
      n++;
    end
    chk(name, {31'd0, evt_valid}, 32'd1);
  endtask

  task automatic settle();
    sw_input = 8'h00; evt_ready = 1'b1;
    repeat (LAT + 4) step();
  endtask

  initial begin
    bit seen_valid, seen_state;
    int ev_n, ev_t[2];
    logic [7:0] ev_r[2], first_rise;
    bit ovr_seen, got_first;
    int idx;

    tbl[0] = '{sw: 8'h00, exp_state: 8'h00};
    tbl[1] = '{sw: 8'hA5, exp_state: 8'hA5};
    tbl[2] = '{sw: 8'h5A, exp_state: 8'h5A};
    tbl[3] = '{sw: 8'hFF, exp_state: 8'hFF};
    tbl[4] = '{sw: 8'h81, exp_state: 8'h81};
    tbl[5] = '{sw: 8'h00, exp_state: 8'h00};

    // Reset with all inputs high
    aresetn = 1'b0; sw_input = 8'hFF; evt_ready = 1'b0;
    repeat (3) begin
      step();
      chk("reset_outputs", {6'd0, sw_state, evt_valid, evt_rise, evt_fall, evt_overrun}, 32'd0);
    end
    aresetn = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == LAT - 1) chk("pre_latency_state", {24'd0, sw_state}, 32'h00);
    end
    chk("post_reset_state", {24'd0, sw_state}, 32'hFF);
    chk("post_reset_valid", {31'd0, evt_valid}, 32'd1);
    chk("post_reset_rise", {24'd0, evt_rise}, 32'hFF);
    chk("post_reset_fall", {24'd0, evt_fall}, 32'h00);
    evt_ready = 1'b1;
    step();
    chk("post_reset_accept", {31'd0, evt_valid}, 32'd0);
    settle();

    // Table of steady levels, consumer always ready
    for (int i = 0; i < 6; i++) begin
      sw_input = tbl[i].sw; evt_ready = 1'b1;
      repeat (LAT + 4) step();
      chk("table_state", {24'd0, sw_state}, {24'd0, tbl[i].exp_state});
      chk("table_valid_idle", {31'd0, evt_valid}, 32'd0);
    end
    settle();

    // Three-cycle glitch on bit 2
    seen_valid = 1'b0; seen_state = 1'b0;
    sw_input = 8'h04;
    repeat (3) begin step(); seen_valid |= evt_valid; seen_state |= sw_state[2]; end
    sw_input = 8'h00;
    repeat (LAT + 3) begin step(); seen_valid |= evt_valid; seen_state |= sw_state[2]; end
    chk("glitch_valid_seen", {31'd0, seen_valid}, DB ? 32'd0 : 32'd1);
    chk("glitch_state_seen", {31'd0, seen_state}, DB ? 32'd0 : 32'd1);

    // Four-cycle pulse on bit 2
    got_first = 1'b0; first_rise = 8'h00;
    sw_input = 8'h04;
    repeat (4) begin
      step();
      if (evt_valid && !got_first) begin got_first = 1'b1; first_rise = evt_rise; end
    end
    sw_input = 8'h00;
    repeat (LAT + 6) begin
      step();
      if (evt_valid && !got_first) begin got_first = 1'b1; first_rise = evt_rise; end
    end
    chk("pulse4_rise", {23'd0, got_first, first_rise}, {23'd0, 1'b1, 8'h04});
    settle();

    // Backpressure: rise then fall on bit 1 while stalled
    evt_ready = 1'b0; sw_input = 8'h02;
    wait_valid("bp_first_event", LAT + 4);
    sw_input = 8'h00;
    repeat (LAT + 2) step();
    chk("bp_valid", {31'd0, evt_valid}, 32'd1);
    chk("bp_rise", {24'd0, evt_rise}, 32'h02);
    chk("bp_fall", {24'd0, evt_fall}, 32'h02);
    chk("bp_overrun", {31'd0, evt_overrun}, 32'd1);
    evt_ready = 1'b1;
    step();
    chk("bp_drop", {31'd0, evt_valid}, 32'd0);
    settle();

    // Back-to-back staggered rises, bit 0 then bit 7
    ev_n = 0; ovr_seen = 1'b0; ev_r[0] = 8'h00; ev_r[1] = 8'h00; ev_t[0] = 0; ev_t[1] = 0;
    sw_input = 8'h01;
    step();
    sw_input = 8'h81;
    for (int k = 0; k < LAT + 3; k++) begin
      step();
      if (evt_valid) begin
        if (ev_n < 2) begin ev_r[ev_n] = evt_rise; ev_t[ev_n] = k; end
        ev_n++;
        if (evt_overrun) ovr_seen = 1'b1;
      end
    end
    chk("b2b_count", ev_n, 32'd2);
    chk("b2b_first", {24'd0, ev_r[0]}, 32'h01);
    chk("b2b_second", {24'd0, ev_r[1]}, 32'h80);
    chk("b2b_adjacent", ev_t[1] - ev_t[0], 32'd1);
    chk("b2b_overrun", {31'd0, ovr_seen}, 32'd0);
    settle();

    // New edge on bit 3 lands on the accept of a held bit-4 event
    evt_ready = 1'b0; sw_input = 8'h10;
    wait_valid("coll_held", LAT + 4);
    sw_input = 8'h18;
    repeat (LAT - 1) step();
    evt_ready = 1'b1;
    step();
    chk("coll_valid", {31'd0, evt_valid}, 32'd1);
    chk("coll_rise", {24'd0, evt_rise}, 32'h08);
    chk("coll_fall", {24'd0, evt_fall}, 32'h00);
    chk("coll_overrun", {31'd0, evt_overrun}, 32'd0);
    step();
    chk("coll_drop", {31'd0, evt_valid}, 32'd0);
    settle();

    // Randomized run against the model, with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        idx = $urandom_range(0, 7);
        sw_input[idx] = ~sw_input[idx];
      end
      evt_ready = ($urandom_range(0, 2) != 0);
      aresetn   = ($urandom_range(0, 399) != 0);
      step();
    end
    aresetn = 1'b1;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
